button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage that turns raw, asynchronous, bouncy push-button inputs into clean synchronous signals for the reaction-timer FSM. Each channel is synchronised, debounced with a per-channel stability counter, and edge-detected into one-cycle press/release pulses. Sits directly between the board buttons and the `go_btn`/`react_btn` inputs of the reaction-timer top level.

## Interface
- `N_BTN`, 2: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 100000: consecutive cycles a synchronised input must differ from the debounced level before the level flips (≥2).
- `LONG_CYCLES`, 2000000: cycles of continuous debounced-high level before a long-press pulse (≥1; used only with `BTN_LONG_PRESS_EN`).

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn_raw`  in  N_BTN  raw button levels, asynchronous to `clk`, active-high.
- `btn_level`  out  N_BTN  debounced level per channel.
- `btn_rise`  out  N_BTN  one-cycle pulse when `btn_level[i]` goes 0→1.
- `btn_fall`  out  N_BTN  one-cycle pulse when `btn_level[i]` goes 1→0.
- `btn_long`  out  N_BTN  one-cycle long-press pulse (tied 0 without `BTN_LONG_PRESS_EN`).

## Operation
- Per channel: two-flop synchroniser `s1→s2`; no logic between the flops.
- Counter width `$clog2(DEBOUNCE_CYCLES)`; compare against `DEBOUNCE_CYCLES-1` (terminal count).
- Each edge, per channel:
  - `s2 == level`: counter cleared to 0.
  - `s2 != level`, count < `DEBOUNCE_CYCLES-1`: count increments.
  - `s2 != level`, count == `DEBOUNCE_CYCLES-1`: level inverts, counter cleared; same edge registers `btn_rise` (new level 1) or `btn_fall` (new level 0).
- Any cycle in which `s2` returns to `level` discards the partial count; glitches shorter than `DEBOUNCE_CYCLES` never reach `btn_level`.
- Rise/fall pulses last exactly one cycle; never both high on one channel in the same cycle.
- Channels fully independent; simultaneous activity on several channels yields simultaneous pulses.
- Reset mid-operation: synchronisers, counters, levels, and pulses clear asynchronously. A button held through reset release is treated as a new press.

## Timing
- Reset values: `btn_level`, `btn_rise`, `btn_fall`, `btn_long` all 0.
- Raw input stable from before edge k: `s1` updates at k, `s2` at k+1. First mismatch is counted at k+2. `btn_level` flips and the rise/fall pulse asserts after edge k+1+`DEBOUNCE_CYCLES`; the pulse deasserts after the next edge.
- End-to-end latency: `DEBOUNCE_CYCLES`+2 edges; all outputs registered.

## Configuration
- `BTN_LONG_PRESS_EN` defined:
  - A per-channel hold counter saturates at `LONG_CYCLES`; it clears while `btn_level` is 0.
  - `btn_long[i]` pulses for one cycle when `btn_level[i]` has been 1 for exactly `LONG_CYCLES` consecutive cycles, counting the rise cycle as 1.
  - At most one long pulse per press. Reset clears the hold counter.
- Undefined: no hold counter is built, and `btn_long` is constant 0.

## Structure
- Shared package `reaction_pkg`: default `DEBOUNCE_CYCLES`/`LONG_CYCLES` constants and the counter-width function.
- Sub-module `debounce_channel`: synchroniser, counter, level, and edge flops (plus hold counter under the macro) for one bit. The top instantiates `N_BTN` copies in a generate loop.

## Test plan
- Clean press, `DEBOUNCE_CYCLES`=4: raw 0→1 sampled at edge 10 and held → `btn_level` 1 after edge 15; `btn_rise` high only in the cycle following edge 15.
- Bounce: raw toggles 1,0,1,0 for one cycle each, then held 1 → exactly one `btn_rise`, occurring 4+2 edges after the final 0→1; no `btn_fall`.
- Glitch: raw high for 3 cycles, `DEBOUNCE_CYCLES`=4 → `btn_level` stays 0; no pulses.
- Release: level 1, raw 1→0 held → `btn_fall` one cycle, 6 edges later; `btn_level` 0.
- Reset mid-count and held button: assert reset during a partial count → all outputs 0 immediately. Keep raw 1, release reset → `btn_rise` after `DEBOUNCE_CYCLES`+2 edges.
- `BTN_LONG_PRESS_EN`, `LONG_CYCLES`=8: hold → one `btn_long` 7 cycles after `btn_rise`, none after. Two channels pressed together → simultaneous, independent pulses.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer button front end: default
// debounce / long-press cycle counts, the per-channel status bundle and
// the counter-width helper.
package reaction_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 2000000;

    // Registered outputs of one conditioned button channel
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic long_press;
    } btn_status_t;

    // Bits needed to hold 0 .. n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board buttons and the conditioner: raw levels
// in, debounced level and one-cycle edge / long-press pulses out.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 2
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [N_BTN-1:0] btn_long;

    // Button source / consumer side
    modport master (
        output btn_raw,
        input  btn_level, btn_rise, btn_fall, btn_long
    );

    // Conditioner side
    modport slave (
        input  btn_raw,
        output btn_level, btn_rise, btn_fall, btn_long
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and registered rise/fall pulses. With BTN_LONG_PRESS_EN defined a
// saturating hold counter also produces a single long-press pulse.
module debounce_channel
    import reaction_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        raw,
    output btn_status_t status
);

    localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic          flip;

    // Level inverts once the mismatch has persisted for the full window
    assign flip = (s2 != level_q) && (cnt_q == TERM);

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Stability counter, debounced level and one-cycle edge pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= flip && !level_q;
            fall_q <= flip && level_q;
            if ((s2 == level_q) || flip) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (flip) begin
                level_q <= !level_q;
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned   HW       = cnt_width(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q;
    logic          long_q;
    logic          level_next;

    // The hold counter tracks the upcoming level so that the rise cycle
    // itself is already counted as the first held cycle.
    assign level_next = level_q ^ flip;

    // Saturating hold counter; the pulse fires only on reaching saturation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= level_next && (hold_q == HOLD_MAX - 1'b1);
            if (!level_next) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign status.long_press = long_q;
`else
    assign status.long_press = 1'b0;
`endif

    assign status.level = level_q;
    assign status.rise  = rise_q;
    assign status.fall  = fall_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: N_BTN independent debounce channels turning raw
// asynchronous push-button levels into clean synchronous level, rise, fall
// and long-press signals. Long-press detection is built only when the
// BTN_LONG_PRESS_EN macro is defined; otherwise btn_long is tied low.
module button_conditioner
    import reaction_pkg::*;
#(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    if ((N_BTN < 1) || (DEBOUNCE_CYCLES < 2) || (LONG_CYCLES < 1)) begin : g_param_check
        $error("button_conditioner: illegal parameter values");
    end

    btn_status_t      status [N_BTN];
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] rise_v;
    logic [N_BTN-1:0] fall_v;
    logic [N_BTN-1:0] long_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
            ,
            .LONG_CYCLES     (LONG_CYCLES)
`endif
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.btn_raw[i]),
            .status (status[i])
        );

        assign level_v[i] = status[i].level;
        assign rise_v[i]  = status[i].rise;
        assign fall_v[i]  = status[i].fall;
        assign long_v[i]  = status[i].long_press;
    end

    assign bus.btn_level = level_v;
    assign bus.btn_rise  = rise_v;
    assign bus.btn_fall  = fall_v;
    assign bus.btn_long  = long_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed press / bounce /
// glitch / release / reset scenarios followed by randomized per-channel
// activity, all compared every cycle against a history-based reference.
module tb_button_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 8;

    logic clk;
    logic reset;

    button_conditioner_if #(.N_BTN(N)) bus ();

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raw value sampled at every edge since reset release. The
    // level flips at an edge when the D synchronised samples feeding it
    // (raw from 2..D+1 edges earlier) all disagree with the current level.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_level, m_rise, m_fall, m_long;
    int           m_run [N];

    function automatic logic sampled(input int idx, input int ch);
        logic [N-1:0] v;
        if (idx < 0) return 1'b0;
        v = hist[idx];
        return v[ch];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_long  = '0;
        for (int ch = 0; ch < N; ch++) m_run[ch] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        int   e;
        logic old;
        logic stable;
        hist.push_back(raw);
        e = hist.size() - 1;
        for (int ch = 0; ch < N; ch++) begin
            old    = m_level[ch];
            stable = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
                if (sampled(e - j, ch) == old) stable = 1'b0;
            end
            m_rise[ch]  = stable && !old;
            m_fall[ch]  = stable && old;
            m_level[ch] = old ^ stable;
            m_run[ch]   = m_level[ch] ? m_run[ch] + 1 : 0;
`ifdef BTN_LONG_PRESS_EN
            m_long[ch]  = (m_run[ch] == L);
`else
            m_long[ch]  = 1'b0;
`endif
        end
    endtask

    // One clock: drive raw, let the edge happen, compare all outputs
    task automatic tick(input logic [N-1:0] v);
        bus.btn_raw = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check("level", 32'(bus.btn_level), 32'(m_level));
        check("rise",  32'(bus.btn_rise),  32'(m_rise));
        check("fall",  32'(bus.btn_fall),  32'(m_fall));
        check("long",  32'(bus.btn_long),  32'(m_long));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(bus.btn_level), 32'd0);
        check({tag, "_rise"},  32'(bus.btn_rise),  32'd0);
        check({tag, "_fall"},  32'(bus.btn_fall),  32'd0);
        check({tag, "_long"},  32'(bus.btn_long),  32'd0);
    endtask

    int           n;
    int           rises;
    int           falls;
    logic [N-1:0] seen;
    logic [N-1:0] cur;
    int           hold [N];

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        bus.btn_raw = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Clean press on channel 0: latency counted from the first edge seeing 1
        repeat (9) tick(2'b00);
        n = 0;
        do begin
            tick(2'b01);
            n++;
        end while (!bus.btn_rise[0] && n < 40);
        check("press_latency", 32'(n), 32'(D + 2));
        repeat (12) tick(2'b01);

        // Release
        n = 0;
        do begin
            tick(2'b00);
            n++;
        end while (!bus.btn_fall[0] && n < 40);
        check("release_latency", 32'(n), 32'(D + 2));
        repeat (4) tick(2'b00);

        // Glitch shorter than the debounce window
        seen = '0;
        repeat (D - 1) begin
            tick(2'b01);
            seen = seen | bus.btn_rise | bus.btn_fall | bus.btn_level;
        end
        repeat (8) begin
            tick(2'b00);
            seen = seen | bus.btn_rise | bus.btn_fall | bus.btn_level;
        end
        check("glitch_quiet", 32'(seen), 32'd0);

        // Bounce 1,0,1,0 then held high: exactly one rise, no fall
        rises = 0;
        falls = 0;
        tick(2'b01); rises += int'(bus.btn_rise[0]); falls += int'(bus.btn_fall[0]);
        tick(2'b00); rises += int'(bus.btn_rise[0]); falls += int'(bus.btn_fall[0]);
        tick(2'b01); rises += int'(bus.btn_rise[0]); falls += int'(bus.btn_fall[0]);
        tick(2'b00); rises += int'(bus.btn_rise[0]); falls += int'(bus.btn_fall[0]);
        n = 0;
        do begin
            tick(2'b01);
            n++;
            rises += int'(bus.btn_rise[0]);
            falls += int'(bus.btn_fall[0]);
        end while (!bus.btn_rise[0] && n < 40);
        check("bounce_latency", 32'(n), 32'(D + 2));
        repeat (10) begin
            tick(2'b01);
            rises += int'(bus.btn_rise[0]);
            falls += int'(bus.btn_fall[0]);
        end
        check("bounce_rises", 32'(rises), 32'd1);
        check("bounce_falls", 32'(falls), 32'd0);
        repeat (10) tick(2'b00);

        // Both channels pressed together
        n = 0;
        do begin
            tick(2'b11);
            n++;
        end while (bus.btn_rise == 2'b00 && n < 40);
        check("dual_rise", 32'(bus.btn_rise), 32'h3);
        check("dual_latency", 32'(n), 32'(D + 2));
`ifdef BTN_LONG_PRESS_EN
        n = 0;
        do begin
            tick(2'b11);
            n++;
        end while (bus.btn_long == 2'b00 && n < 40);
        check("long_delay", 32'(n), 32'(L - 1));
        check("long_dual", 32'(bus.btn_long), 32'h3);
        seen = '0;
        repeat (20) begin
            tick(2'b11);
            seen = seen | bus.btn_long;
        end
        check("long_once", 32'(seen), 32'd0);
`else
        seen = '0;
        repeat (30) begin
            tick(2'b11);
            seen = seen | bus.btn_long;
        end
        check("long_tied_low", 32'(seen), 32'd0);
`endif

        // Reset during a partial release count with the button held again
        repeat (D - 1) tick(2'b00);
        bus.btn_raw = 2'b01;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            tick(2'b01);
            n++;
        end while (!bus.btn_rise[0] && n < 40);
        check("post_reset_press", 32'(n), 32'(D + 2));
        repeat (10) tick(2'b00);

        // Randomized independent activity, mixing short bounces and long holds
        cur = '0;
        for (int ch = 0; ch < N; ch++) hold[ch] = 0;
        repeat (1500) begin
            for (int ch = 0; ch < N; ch++) begin
                if (hold[ch] == 0) begin
                    cur[ch] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0)
                        hold[ch] = int'($urandom_range(D, 3 * L));
                    else
                        hold[ch] = int'($urandom_range(1, D + 1));
                end
                hold[ch] = hold[ch] - 1;
            end
            tick(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
